div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL run on one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; 0 = reset.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  input  32  dividend.
- opdata2_i  input  32  divisor.
- start_i  input  1  request; held high by the execute stage until the result is consumed.
- annul_i  input  1  cancel the in-flight divide (pipeline flush).
- result_o  output  64  {remainder[63:32], quotient[31:0]}; the execute stage routes these to hi_o and lo_o.
- ready_o  output  1  result_o valid.
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The block SHALL use a 4-state FSM: FREE, BYZERO, ON, END.
REQ-005 In FREE, at an edge with start_i=1 and annul_i=0:
- Operands and signed_div_i SHALL be latched; this edge is called E0.
- Next state SHALL be BYZERO if opdata2_i==0, otherwise ON.
REQ-006 In FREE with start_i=0 or annul_i=1, the state SHALL remain FREE, with ready_o=0 and result_o=0.
REQ-007 Operand conditioning at E0, for a signed request only:
- A negative operand SHALL be replaced by its two's-complement magnitude.
- An unsigned request SHALL use the operands unchanged.
REQ-008 ON SHALL perform one restoring radix-2 iteration per edge, using a 65-bit shift/subtract register and a 6-bit counter.
- Iteration i SHALL occur at edge Ei, for i = 1..32.
REQ-009 At E33 the FSM SHALL enter END with result_o loaded and ready_o=1.
- Busy latency is exactly 33 edges after E0.
REQ-010 Signed sign fix-up, applied when result_o is loaded:
- The quotient SHALL be negated when the dividend and divisor signs differ.
- The remainder SHALL be negated when the dividend is negative.
- Arithmetic SHALL be modulo 2^32.
REQ-011 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0, with no trap.
REQ-012 BYZERO SHALL move to END at the next edge, with result_o = 0 and ready_o = 1 from that edge onward.
REQ-013 END SHALL hold result_o and ready_o=1 while start_i=1.
- At an edge with start_i=0, the FSM SHALL return to FREE, and ready_o and result_o SHALL go to 0.
REQ-014 annul_i=1 at any edge in ON or BYZERO SHALL force FREE, with ready_o=0 and result_o=0.
- The aborted result SHALL never appear.
REQ-015 annul_i in END SHALL have the same effect as start_i=0.
REQ-016 Operand changes while not in FREE SHALL be ignored, since only the values latched at E0 are used.
REQ-017 A new request SHALL be accepted only from FREE.
- Back-to-back divides therefore need start_i low for at least one edge between them.
REQ-018 Simultaneous start_i=1 and annul_i=1 in FREE SHALL leave the FSM in FREE.

Reset
REQ-019 rst=0 SHALL force the following asynchronously, from any state including mid-iteration:
- state = FREE;
- ready_o = 0;
- result_o = 0;
- counter = 0;
- internal dividend register = 0.
REQ-020 After rst deasserts, the first request SHALL behave per REQ-005 with no residue from the aborted operation.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- V1: unsigned 100/7, start held -> ready_o rises after E33; result_o = 0x00000002_0000000E; held until start_i drops, then 0 the next cycle.
- V2: signed 0xFFFFFFF9 / 0x00000002 (-7/2) -> result_o = 0xFFFFFFFF_FFFFFFFD (rem -1, quo -3).
- V3: signed 0x80000000 / 0xFFFFFFFF -> result_o = 0x00000000_80000000 at E33.
- V4: divisor 0 (either mode) -> ready_o high after E1; result_o = 0.
- V5: annul_i pulsed at E10 of 1000/3 -> ready_o stays 0 through E40; a following unsigned 1000/3 gives 0x00000001_0000014D.
- V6: rst pulsed low mid-ON (E15) with no clock edge -> ready_o=0 and result_o=0 immediately; a subsequent 9/3 unsigned gives 0x00000000_00000003.

Source files
------------

// File: rtl/div.sv
// Multi-cycle 32-bit integer divider (DIV / DIVU) for the execute stage.
// A restoring radix-2 divider that takes 33 clock edges after the request edge.
// It supports signed and unsigned operands, returns 0 on a zero divisor, and
// can be cancelled by a pipeline flush.
// result_o = {remainder, quotient}.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_r;
    logic [5:0]  cnt_r;
    // {partial remainder, dividend bits still to consume / quotient bits, spare}
    logic [64:0] dividend_r;
    logic [31:0] divisor_r;
    logic        neg_quo_r;
    logic        neg_rem_r;

    logic [31:0] op1_mag_s;
    logic [31:0] op2_mag_s;
    logic [32:0] diff_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    // Two's-complement negation, modulo 2^32.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Conditionally negate a 32-bit value.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? neg32(v) : v;
    endfunction

    // Operand magnitudes at request time, plus the trial subtract and the signed result fix-up.
    always_comb begin
        op1_mag_s = cond_neg32(opdata1_i, signed_div_i & opdata1_i[31]);
        op2_mag_s = cond_neg32(opdata2_i, signed_div_i & opdata2_i[31]);
        diff_s    = {1'b0, dividend_r[63:32]} - {1'b0, divisor_r};
        quo_s     = cond_neg32(dividend_r[31:0], neg_quo_r);
        rem_s     = cond_neg32(dividend_r[64:33], neg_rem_r);
    end

    // Divider FSM: latch the request, iterate 32 times, then hold the result until it is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= FREE;
            cnt_r      <= 6'd0;
            dividend_r <= 65'd0;
            divisor_r  <= 32'd0;
            neg_quo_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                    if (start_i && !annul_i) begin
                        dividend_r <= {32'd0, op1_mag_s, 1'b0};
                        divisor_r  <= op2_mag_s;
                        neg_quo_r  <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_r  <= signed_div_i & opdata1_i[31];
                        cnt_r      <= 6'd0;
                        state_r    <= (opdata2_i == 32'd0) ? BYZERO : ON;
                    end else begin
                        state_r <= FREE;
                    end
                end
                BYZERO: begin
                    result_o <= 64'd0;
                    if (annul_i) begin
                        ready_o <= 1'b0;
                        state_r <= FREE;
                    end else begin
                        ready_o <= 1'b1;
                        state_r <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        cnt_r    <= 6'd0;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                        state_r  <= FREE;
                    end else if (cnt_r == 6'd32) begin
                        result_o <= {rem_s, quo_s};
                        ready_o  <= 1'b1;
                        cnt_r    <= 6'd0;
                        state_r  <= END;
                    end else begin
                        // A borrow means the divisor did not fit: shift in a 0 quotient bit.
                        if (diff_s[32]) begin
                            dividend_r <= {dividend_r[63:0], 1'b0};
                        end else begin
                            dividend_r <= {diff_s[31:0], dividend_r[31:0], 1'b1};
                        end
                        cnt_r    <= cnt_r + 6'd1;
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                        state_r  <= ON;
                    end
                end
                END: begin
                    if (start_i && !annul_i) begin
                        state_r <= END;
                    end else begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                        state_r  <= FREE;
                    end
                end
                default: begin
                    cnt_r    <= 6'd0;
                    result_o <= 64'd0;
                    ready_o  <= 1'b0;
                    state_r  <= FREE;
                end
            endcase
        end
    end

endmodule
